// File: rtl/at24_pkg.sv
// Shared types and gate patterns for the H-bridge sequencer and its users.
package at24_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'd0,
    MODE_PLUS    = 3'd1,
    MODE_MINUS   = 3'd2,
    MODE_PAUSE_P = 3'd3,
    MODE_PAUSE_N = 3'd4
  } bridge_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_DEAD = 2'd2
  } bridge_state_t;

  localparam logic [3:0] PAT_TOP_OFF     = 4'b0000;
  localparam logic [3:0] PAT_BOT_OFF     = 4'b0000;
  localparam logic [3:0] PAT_TOP_PLUS    = 4'b0001;
  localparam logic [3:0] PAT_BOT_PLUS    = 4'b0010;
  localparam logic [3:0] PAT_TOP_MINUS   = 4'b0010;
  localparam logic [3:0] PAT_BOT_MINUS   = 4'b0001;
  localparam logic [3:0] PAT_TOP_PAUSE_P = 4'b0100;
  localparam logic [3:0] PAT_BOT_PAUSE_P = 4'b1000;
  localparam logic [3:0] PAT_TOP_PAUSE_N = 4'b1000;
  localparam logic [3:0] PAT_BOT_PAUSE_N = 4'b0100;

  function automatic logic mode_is_valid(input logic [2:0] code);
    return code <= 3'd4;
  endfunction

  function automatic logic [3:0] pat_top(input bridge_mode_t m);
    case (m)
      MODE_PLUS:    return PAT_TOP_PLUS;
      MODE_MINUS:   return PAT_TOP_MINUS;
      MODE_PAUSE_P: return PAT_TOP_PAUSE_P;
      MODE_PAUSE_N: return PAT_TOP_PAUSE_N;
      default:      return PAT_TOP_OFF;
    endcase
  endfunction

  function automatic logic [3:0] pat_bot(input bridge_mode_t m);
    case (m)
      MODE_PLUS:    return PAT_BOT_PLUS;
      MODE_MINUS:   return PAT_BOT_MINUS;
      MODE_PAUSE_P: return PAT_BOT_PAUSE_P;
      MODE_PAUSE_N: return PAT_BOT_PAUSE_N;
      default:      return PAT_BOT_OFF;
    endcase
  endfunction

  // Indicator vector order: {pause_n, pause_p, minus, plus}.
  function automatic logic [3:0] pat_ind(input bridge_mode_t m);
    case (m)
      MODE_PLUS:    return 4'b0001;
      MODE_MINUS:   return 4'b0010;
      MODE_PAUSE_P: return 4'b0100;
      MODE_PAUSE_N: return 4'b1000;
      default:      return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/bridge_sequencer.sv
// Break-before-make H-bridge sequencer: dead time between conducting
// patterns, minimum on-time, and a one-cycle kill path.
module bridge_sequencer
  import at24_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES   = 50,
  parameter int unsigned MIN_ON_CYCLES = 500,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [2:0] req_mode,
  output logic       req_ready,
  input  logic       kill,
  output logic [3:0] o_top,
  output logic [3:0] o_bot,
  output logic       o_plus,
  output logic       o_minus,
  output logic       o_pause_p,
  output logic       o_pause_n,
  output logic       busy,
  output logic       err_bad_mode
);

  typedef struct packed {
    bridge_state_t    state;
    logic [CNT_W-1:0] cnt;
    bridge_mode_t     target;
    bridge_mode_t     mode;
    logic [3:0]       top;
    logic [3:0]       bot;
    logic [3:0]       ind;
    logic             busy;
    logic             err;
  } regs_t;

  localparam regs_t REGS_RST = '{S_IDLE, '0, MODE_OFF, MODE_OFF, '0, '0, '0, 1'b0, 1'b0};

  regs_t        r;
  regs_t        n;
  logic         accept;
  bridge_mode_t req_m;

  always_comb begin
    req_ready = 1'b0;
    case (r.state)
      S_IDLE:  req_ready = ~kill;
      S_ON:    req_ready = (r.cnt == '0) & ~kill;
      default: req_ready = 1'b0;
    endcase
  end

  assign accept = req_valid & req_ready;
  assign req_m  = bridge_mode_t'(req_mode);

  always_comb begin
    n     = r;
    n.err = 1'b0;
    case (r.state)
      S_IDLE: begin
        if (accept) begin
          if (!mode_is_valid(req_mode)) begin
            n.err = 1'b1;
          end else if (req_m != MODE_OFF) begin
            n.state = S_ON;
            n.mode  = req_m;
            n.cnt   = CNT_W'(MIN_ON_CYCLES);
            n.top   = pat_top(req_m);
            n.bot   = pat_bot(req_m);
            n.ind   = pat_ind(req_m);
          end
        end
      end
      S_ON: begin
        if (r.cnt != '0) n.cnt = r.cnt - CNT_W'(1);
        if (accept) begin
          if (!mode_is_valid(req_mode)) begin
            n.err = 1'b1;
          end else if (req_m != r.mode) begin
            n.state  = S_DEAD;
            n.target = req_m;
            n.mode   = MODE_OFF;
            n.cnt    = CNT_W'(DEAD_CYCLES);
            n.top    = '0;
            n.bot    = '0;
            n.ind    = '0;
          end
        end
      end
      S_DEAD: begin
        // Leave on cnt==1 so the zero pattern is held exactly DEAD_CYCLES cycles.
        if (r.cnt == CNT_W'(1)) begin
          if (r.target == MODE_OFF) begin
            n.state = S_IDLE;
            n.cnt   = '0;
          end else begin
            n.state = S_ON;
            n.mode  = r.target;
            n.cnt   = CNT_W'(MIN_ON_CYCLES);
            n.top   = pat_top(r.target);
            n.bot   = pat_bot(r.target);
            n.ind   = pat_ind(r.target);
          end
          n.target = MODE_OFF;
        end else begin
          n.cnt = r.cnt - CNT_W'(1);
        end
      end
      default: n = REGS_RST;
    endcase
    if (kill) begin
      n.state  = S_DEAD;
      n.target = MODE_OFF;
      n.mode   = MODE_OFF;
      n.cnt    = CNT_W'(DEAD_CYCLES);
      n.top    = '0;
      n.bot    = '0;
      n.ind    = '0;
      n.err    = 1'b0;
    end
    n.busy = (n.state != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r <= REGS_RST;
    else     r <= n;
  end

  assign o_top        = r.top;
  assign o_bot        = r.bot;
  assign o_plus       = r.ind[0];
  assign o_minus      = r.ind[1];
  assign o_pause_p    = r.ind[2];
  assign o_pause_n    = r.ind[3];
  assign busy         = r.busy;
  assign err_bad_mode = r.err;

endmodule

// File: tb/tb_bridge_sequencer.sv
// Randomized bench for bridge_sequencer against a timestamp-based model.
module tb_bridge_sequencer;
  import at24_pkg::*;

  localparam int DEAD   = 50;
  localparam int MIN_ON = 500;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_mode = 3'd0;
  logic       req_ready;
  logic       kill = 1'b0;
  logic [3:0] o_top, o_bot;
  logic       o_plus, o_minus, o_pause_p, o_pause_n;
  logic       busy, err_bad_mode;

  bridge_sequencer #(.DEAD_CYCLES(DEAD), .MIN_ON_CYCLES(MIN_ON), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .kill(kill), .o_top(o_top), .o_bot(o_bot),
    .o_plus(o_plus), .o_minus(o_minus), .o_pause_p(o_pause_p),
    .o_pause_n(o_pause_n), .busy(busy), .err_bad_mode(err_bad_mode)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: edge index, visible mode, edge where dead time ends (0 = none),
  // pending target, edge the current conducting mode was entered.
  int       edge_no;
  int       shown;
  int       dead_end;
  int       target;
  int       on_edge;
  logic     m_err;

  logic [3:0] top_tab [8];
  logic [3:0] bot_tab [8];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_ready(input logic k);
    if (k || dead_end != 0) return 1'b0;
    if (shown == 0) return 1'b1;
    return (edge_no + 1 - on_edge) > MIN_ON;
  endfunction

  task automatic model_reset();
    shown = 0; dead_end = 0; target = 0; on_edge = 0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic k, input logic v, input logic [2:0] m);
    logic rdy;
    rdy = exp_ready(k);
    edge_no++;
    m_err = 1'b0;
    if (k) begin
      dead_end = edge_no + DEAD; target = 0; shown = 0;
    end else if (dead_end != 0) begin
      if (edge_no == dead_end) begin
        dead_end = 0; shown = target;
        if (target != 0) on_edge = edge_no;
      end
    end else if (v && rdy) begin
      if (m > 3'd4) m_err = 1'b1;
      else if (shown == 0) begin
        if (m != 3'd0) begin shown = int'(m); on_edge = edge_no; end
      end else if (int'(m) != shown) begin
        dead_end = edge_no + DEAD; target = int'(m); shown = 0;
      end
    end
  endtask

  task automatic check_outputs(input logic k);
    logic [3:0] ind;
    ind = (shown == 0) ? 4'b0000 : 4'(1 << (shown - 1));
    check_eq("top", 32'(o_top), 32'(top_tab[shown]));
    check_eq("bot", 32'(o_bot), 32'(bot_tab[shown]));
    check_eq("ind", 32'({o_pause_n, o_pause_p, o_minus, o_plus}), 32'(ind));
    check_eq("busy", 32'(busy), 32'(dead_end != 0 || shown != 0));
    check_eq("err", 32'(err_bad_mode), 32'(m_err));
    check_eq("ready", 32'(req_ready), 32'(exp_ready(k)));
    check_eq("shoot", 32'(o_top & o_bot), 32'd0);
  endtask

  task automatic step(input logic k, input logic v, input logic [2:0] m);
    kill = k; req_valid = v; req_mode = m;
    @(negedge clk);
    check_outputs(k);
    @(posedge clk);
    model_edge(k, v, m);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1 check_eq("ready_after_rst", 32'(req_ready), 32'd1);
    @(posedge clk);
    model_edge(1'b0, 1'b0, 3'd0);
    #1;
  endtask

  initial begin
    int guard;
    top_tab = '{PAT_TOP_OFF, PAT_TOP_PLUS, PAT_TOP_MINUS, PAT_TOP_PAUSE_P, PAT_TOP_PAUSE_N, 4'h0, 4'h0, 4'h0};
    bot_tab = '{PAT_BOT_OFF, PAT_BOT_PLUS, PAT_BOT_MINUS, PAT_BOT_PAUSE_P, PAT_BOT_PAUSE_N, 4'h0, 4'h0, 4'h0};
    edge_no = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_top", 32'(o_top), 32'd0);
    check_eq("rst_bot", 32'(o_bot), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    release_reset();

    // Directed: PLUS, same-mode re-request, MINUS via dead time, bad mode, kill.
    step(1'b0, 1'b1, 3'd1);
    idle(MIN_ON + 2);
    step(1'b0, 1'b1, 3'd1);
    idle(3);
    step(1'b0, 1'b1, 3'd2);
    idle(DEAD + 5);
    idle(MIN_ON);
    step(1'b0, 1'b1, 3'd6);
    idle(3);
    step(1'b0, 1'b1, 3'd3);
    idle(DEAD + MIN_ON + 2);
    step(1'b1, 1'b1, 3'd1);
    idle(DEAD + 3);

    for (int i = 0; i < 25000; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)));
    end

    // Async reset in the middle of dead time, with 20 dead cycles left.
    step(1'b1, 1'b0, 3'd0);
    guard = 0;
    while (dead_end - edge_no != 20 && guard < 100) begin
      step(1'b0, 1'b0, 3'd0);
      guard++;
    end
    check_eq("dead_reach", 32'(guard < 100), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_top", 32'(o_top), 32'd0);
    check_eq("mid_rst_bot", 32'(o_bot), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_ind", 32'({o_pause_n, o_pause_p, o_minus, o_plus}), 32'd0);
    @(posedge clk);
    release_reset();
    step(1'b0, 1'b1, 3'd4);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
